// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback request bus shared by all requesters
interface regfile_wr_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wr_hold;

  modport master (
    output req_valid, req_addr, req_data, wr_hold,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_hold,
    output req_ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin (or RFARB_FIXED_PRIORITY_EN fixed priority) register file write port arbiter
module regfile_wr_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wr_arbiter_if.slave req,
  output logic               sig_regWrite,
  output logic [ADDR_W-1:0]  wrReg_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [1:0]         grant_id,
  output logic [15:0]        wr_count
);

  logic [1:0] last_grant;
  logic [1:0] sel;
  logic       found;
  logic       accept;

  // Scan from lowest to highest priority so the last match is the winner.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
`ifdef RFARB_FIXED_PRIORITY_EN
      if (req.req_valid[k-1]) begin
        sel   = 2'(k - 1);
        found = 1'b1;
      end
`else
      if (req.req_valid[(int'(last_grant) + k) % NREQ]) begin
        sel   = 2'((int'(last_grant) + k) % NREQ);
        found = 1'b1;
      end
`endif
    end
  end

  assign accept        = found & ~req.wr_hold & rst_n;
  assign req.req_ready = accept ? (NREQ'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_regWrite <= 1'b0;
      wrReg_addr   <= '0;
      wr_data      <= '0;
      grant_id     <= '0;
      wr_count     <= '0;
      last_grant   <= 2'(NREQ - 1);
    end else begin
      if (sig_regWrite) wr_count <= wr_count + 16'd1;
      sig_regWrite <= accept;
      if (accept) begin
        wrReg_addr <= req.req_addr[int'(sel)*ADDR_W +: ADDR_W];
        wr_data    <= req.req_data[int'(sel)*DATA_W +: DATA_W];
        grant_id   <= sel;
        last_grant <= sel;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - randomized and directed bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sig_regWrite;
  logic [ADDR_W-1:0] wrReg_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        grant_id;
  logic [15:0]       wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (bus.slave),
    .sig_regWrite (sig_regWrite),
    .wrReg_addr   (wrReg_addr),
    .wr_data      (wr_data),
    .grant_id     (grant_id),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  int                m_last;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_id;
  logic [15:0]       m_count;
  logic [NREQ-1:0]   m_acc;
  logic [DATA_W-1:0] rf [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (!rst_n || bus.wr_hold) return r;
    for (int k = 0; k < NREQ; k++) begin
`ifdef RFARB_FIXED_PRIORITY_EN
      int i = k;
`else
      int i = (m_last + 1 + k) % NREQ;
`endif
      if (bus.req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = NREQ - 1; m_we = 0; m_addr = '0; m_data = '0; m_id = '0; m_count = '0; m_acc = '0;
    end else begin
      logic [NREQ-1:0] r;
      if (m_we) m_count = m_count + 16'd1;
      r     = exp_ready();
      m_acc = r;
      m_we  = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) begin
          m_we   = 1;
          m_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
          m_data = bus.req_data[i*DATA_W +: DATA_W];
          m_id   = 2'(i);
          m_last = i;
        end
      end
    end
  end

  always @(posedge clk) if (sig_regWrite) rf[wrReg_addr] <= wr_data;

  always @(negedge clk) begin
    check("ready", 32'(bus.req_ready), 32'(exp_ready()));
    check("regWrite", 32'(sig_regWrite), 32'(m_we));
    check("wr_count", 32'(wr_count), 32'(m_count));
    if (m_we) begin
      check("addr", 32'(wrReg_addr), 32'(m_addr));
      check("data", 32'(wr_data), 32'(m_data));
      check("grant_id", 32'(grant_id), 32'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid[i] = v;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.wr_hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.wr_hold   = 1'b0;
    tick();
    #1;
    check("reset_we", 32'(sig_regWrite), 32'd0);
    check("reset_count", 32'(wr_count), 32'd0);
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    do_reset();

    // Single request from requester 1
    set_req(1, 1'b1, 3'd5, 16'h00AA);
    #1 check("single_ready", 32'(bus.req_ready), 32'b10);
    tick();
    set_req(1, 1'b0, 3'd5, 16'h00AA);
    #1;
    check("single_we", 32'(sig_regWrite), 32'd1);
    check("single_addr", 32'(wrReg_addr), 32'd5);
    check("single_data", 32'(wr_data), 32'h00AA);
    check("single_id", 32'(grant_id), 32'd1);
    tick();
    #1 check("single_count", 32'(wr_count), 32'd1);

`ifndef RFARB_FIXED_PRIORITY_EN
    // Contention: strict alternation starting at 0
    do_reset();
    set_req(0, 1'b1, 3'd1, 16'h0101);
    set_req(1, 1'b1, 3'd3, 16'h0303);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 5) bus.req_valid = '0;
      #1;
      check("rr_we", 32'(sig_regWrite), 32'd1);
      check("rr_order", 32'(grant_id), 32'(c % 2));
    end
    tick();
    #1;
    check("rr_we_off", 32'(sig_regWrite), 32'd0);
    check("rr_count", 32'(wr_count), 32'd6);

    // Hold after first grant; requester 1 goes first afterwards
    do_reset();
    set_req(0, 1'b1, 3'd4, 16'h4444);
    set_req(1, 1'b1, 3'd7, 16'h7777);
    tick();
    bus.wr_hold = 1'b1;
    #1;
    check("hold_ready0", 32'(bus.req_ready), 32'd0);
    check("hold_we0", 32'(sig_regWrite), 32'd1);
    check("hold_id0", 32'(grant_id), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_we", 32'(sig_regWrite), 32'd0);
    end
    tick();
    bus.wr_hold = 1'b0;
    #1 check("release_ready", 32'(bus.req_ready), 32'b10);
    tick();
    bus.req_valid = '0;
    #1 check("release_id", 32'(grant_id), 32'd1);
`else
    // Fixed priority: requester 0 always wins
    do_reset();
    set_req(0, 1'b1, 3'd1, 16'h0101);
    set_req(1, 1'b1, 3'd3, 16'h0303);
    for (int c = 0; c < 4; c++) begin
      #1 check("fp_ready", 32'(bus.req_ready), 32'b01);
      tick();
      #1 check("fp_id", 32'(grant_id), 32'd0);
    end
    bus.req_valid = '0;
`endif

    // Same-address ordering
    do_reset();
    set_req(0, 1'b1, 3'd2, 16'h1111);
    tick();
    set_req(0, 1'b0, 3'd2, 16'h1111);
    set_req(1, 1'b1, 3'd2, 16'h2222);
    #1 check("same_first", 32'(wr_data), 32'h1111);
    tick();
    set_req(1, 1'b0, 3'd2, 16'h2222);
    #1 check("same_second", 32'(wr_data), 32'h2222);
    tick();
    #1 check("same_rf2", 32'(rf[2]), 32'h2222);

    // Reset while a write is on the port
    do_reset();
    set_req(0, 1'b1, 3'd6, 16'hBEEF);
    set_req(1, 1'b1, 3'd3, 16'h3333);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_we", 32'(sig_regWrite), 32'd0);
    check("mid_addr", 32'(wrReg_addr), 32'd0);
    check("mid_data", 32'(wr_data), 32'd0);
    check("mid_count", 32'(wr_count), 32'd0);
    check("mid_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 check("mid_first_ready", 32'(bus.req_ready), 32'b01);
    tick();
    #1 check("mid_first_id", 32'(grant_id), 32'd0);

    // Randomized traffic with holds and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || m_acc[i])
          set_req(i, $urandom_range(0, 2) != 0, ADDR_W'($urandom), DATA_W'($urandom));
      end
      bus.wr_hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    // Counter wrap
    do_reset();
    set_req(0, 1'b1, 3'd1, 16'h5A5A);
    repeat (65536) tick();
    bus.req_valid = '0;
    #1 check("count_ffff", 32'(wr_count), 32'h0000FFFF);
    tick();
    #1 check("count_wrap", 32'(wr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
